truth_table_sweeper: RTL

Synthesizable, self-checking exhaustive stimulus engine for combinational blocks with N_IN inputs and one output. On start it waits a settle period, then drives every input vector 0..2^N_IN-1 for a fixed hold window. At the end of each window it samples the DUT output and compares it against a parameterised expected truth table. It reports the mismatch count and the first failing vector. Sits between the board-level control (button/switch) and the DUT, replacing hand-written per-function sweeps.

---
 rtl/truth_table_sweeper.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/truth_table_sweeper.sv
// Exhaustive truth-table sweeper: drives every N_IN-bit vector to a combinational DUT,
// samples its single output at the end of each hold window and tallies mismatches.
module truth_table_sweeper #(
  parameter int N_IN        = 4,
  parameter int HOLD_CYCLES = 30,
  parameter int PRE_DELAY   = 300,
  parameter logic [(1<<N_IN)-1:0] EXPECTED = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            start,
  input  logic            loop,
  input  logic            dut_y,
  output logic [N_IN-1:0] stim,
  output logic            busy,
  output logic            done,
  output logic            pass,
  output logic [N_IN:0]   err_count,
  output logic [N_IN-1:0] first_fail_idx,
  output logic            first_fail_valid,
  output logic [1:0]      dbg_state
);

  localparam int NV = 1 << N_IN;
  localparam int DW = (PRE_DELAY > 1) ? $clog2(PRE_DELAY) : 1;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

  localparam logic [DW-1:0] PRE_LAST  = DW'((PRE_DELAY > 0) ? PRE_DELAY - 1 : 0);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [N_IN:0] IDX_LAST  = (N_IN + 1)'(NV - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_PRE_WAIT = 2'd1,
    S_APPLY    = 2'd2,
    S_DONE     = 2'd3
  } state_t;

  state_t          state, state_n;
  logic [DW-1:0]   pre_cnt, pre_cnt_n;
  logic [HW-1:0]   hold_cnt, hold_cnt_n;
  logic [N_IN:0]   idx, idx_n;
  logic [N_IN-1:0] stim_n;
  logic            busy_n, done_n, pass_n;
  logic [N_IN:0]   err_n;
  logic [N_IN-1:0] ffi_n;
  logic            ffv_n;
  logic            launch;

  assign dbg_state = state;

  // start is a level request, honoured only from IDLE or DONE; loop re-arms from DONE.
  always_comb begin
    state_n    = state;
    pre_cnt_n  = pre_cnt;
    hold_cnt_n = hold_cnt;
    idx_n      = idx;
    stim_n     = stim;
    err_n      = err_count;
    ffi_n      = first_fail_idx;
    ffv_n      = first_fail_valid;
    pass_n     = pass;
    launch     = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) launch = 1'b1;
      end

      S_PRE_WAIT: begin
        if (pre_cnt == PRE_LAST) begin
          state_n    = S_APPLY;
          idx_n      = '0;
          hold_cnt_n = '0;
          stim_n     = '0;
        end else begin
          pre_cnt_n = pre_cnt + DW'(1);
        end
      end

      S_APPLY: begin
        if (hold_cnt == HOLD_LAST) begin
          if (dut_y != EXPECTED[idx[N_IN-1:0]]) begin
            err_n = err_count + (N_IN + 1)'(1);
            if (!first_fail_valid) begin
              ffi_n = idx[N_IN-1:0];
              ffv_n = 1'b1;
            end
          end
          if (idx == IDX_LAST) begin
            // pass reflects the final compare made on this same edge
            state_n = S_DONE;
            pass_n  = (err_n == '0);
          end else begin
            idx_n      = idx + (N_IN + 1)'(1);
            hold_cnt_n = '0;
            stim_n     = idx_n[N_IN-1:0];
          end
        end else begin
          hold_cnt_n = hold_cnt + HW'(1);
        end
      end

      S_DONE: begin
        if (start || loop) launch = 1'b1;
      end

      default: state_n = S_IDLE;
    endcase

    if (launch) begin
      err_n      = '0;
      ffi_n      = '0;
      ffv_n      = 1'b0;
      pass_n     = 1'b0;
      pre_cnt_n  = '0;
      hold_cnt_n = '0;
      idx_n      = '0;
      stim_n     = '0;
      state_n    = (PRE_DELAY == 0) ? S_APPLY : S_PRE_WAIT;
    end

    busy_n = (state_n == S_PRE_WAIT) || (state_n == S_APPLY);
    done_n = (state_n == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state            <= S_IDLE;
      pre_cnt          <= '0;
      hold_cnt         <= '0;
      idx              <= '0;
      stim             <= '0;
      busy             <= 1'b0;
      done             <= 1'b0;
      pass             <= 1'b0;
      err_count        <= '0;
      first_fail_idx   <= '0;
      first_fail_valid <= 1'b0;
    end else begin
      state            <= state_n;
      pre_cnt          <= pre_cnt_n;
      hold_cnt         <= hold_cnt_n;
      idx              <= idx_n;
      stim             <= stim_n;
      busy             <= busy_n;
      done             <= done_n;
      pass             <= pass_n;
      err_count        <= err_n;
      first_fail_idx   <= ffi_n;
      first_fail_valid <= ffv_n;
    end
  end

endmodule
